// File: rtl/reg_file_sb.sv
// ID-stage integer register file with a per-register pending-write scoreboard.
// Optional write-to-read bypass is enabled by defining RF_WR_BYPASS_EN.
module reg_file_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int NUM_RD = 2,
    parameter  int CNT_W  = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wd,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    output logic                   sb_full,
    input  logic                   flush,
    output logic                   sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  mem     [NREG];
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;
    logic             err_set;

    assign sb_full = iss_valid && (iss_rd != '0) && (cnt[iss_rd] == CNT_MAX);

    // x0 never takes part in the scoreboard
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (iss_valid && !sb_full) inc_v[iss_rd] = 1'b1;
        if (we) dec_v[waddr] = 1'b1;
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
    end

    always_comb begin
        err_set = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (dec_v[r] && !inc_v[r] && cnt[r] == '0) err_set = 1'b1;
            if (flush) begin
                cnt_nxt[r] = '0;
            end else if (inc_v[r] && !dec_v[r]) begin
                cnt_nxt[r] = cnt[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r] && cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (we && waddr != '0) mem[waddr] <= wd;
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (err_set) sb_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
`ifdef RF_WR_BYPASS_EN
        logic hit;
        assign hit = we && (waddr != '0) && (a == waddr);
        assign rd_data[i*XLEN +: XLEN] =
            hit ? wd : ((a == '0) ? '0 : mem[a]);
        // the retiring write is the last one outstanding
        assign rd_busy[i] = (a != '0) && (cnt[a] != '0) &&
                            !(hit && cnt[a] == CNT_W'(1));
`else
        assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 : mem[a];
        assign rd_busy[i] = (a != '0) && (cnt[a] != '0);
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb (default parameters).
// Expectations are queued by the stimulus and checked on the falling edge.
module tb_reg_file_sb;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ra0, ra1;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_busy;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wd;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          sb_full;
    logic          flush;
    logic          sb_err;

    assign rd_addr = {ra1, ra0};

    reg_file_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .waddr(waddr), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .sb_full(sb_full),
        .flush(flush), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef RF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string n, input int k, input logic [31:0] v);
        chk_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        waddr     = '0;
        wd        = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = rd_data[31:0];
                1:       act = rd_data[63:32];
                2:       act = {30'd0, rd_busy};
                3:       act = {31'd0, sb_full};
                default: act = {31'd0, sb_err};
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        ra0 = 5;
        ra1 = 0;
        cyc();
        chk("rst_d0", 0, 0);
        chk("rst_busy", 2, 0);
        chk("rst_err", 4, 0);
        cyc(); rst = 1'b1;
        cyc(); we = 1; waddr = 5; wd = 32'hDEADBEEF;
        cyc(); idle();
        chk("wr_x5", 0, 32'hDEADBEEF);
        cyc(); rst = 1'b0;
        chk("rst_mid_d0", 0, 0);
        chk("rst_mid_busy", 2, 0);
        chk("rst_mid_err", 4, 0);
        cyc(); rst = 1'b1;

        // x0 protection
        cyc();
        ra0 = 0; we = 1; waddr = 0; wd = 32'hFFFFFFFF;
        iss_valid = 1; iss_rd = 0;
        chk("x0_full", 3, 0);
        chk("x0_d", 0, 0);
        chk("x0_busy", 2, 0);
        cyc(); idle();
        chk("x0_after_d", 0, 0);
        chk("x0_after_busy", 2, 0);

        // saturate x3
        ra0 = 3; iss_valid = 1; iss_rd = 3;
        chk("x3_full_p0", 3, 0);
        cyc(); chk("x3_busy_p1", 2, 1); chk("x3_full_p1", 3, 0);
        cyc(); chk("x3_full_p2", 3, 0);
        cyc(); chk("x3_full_p3", 3, 1); chk("x3_busy_p3", 2, 1);
        cyc(); chk("x3_full_hold", 3, 1);
        cyc(); idle(); we = 1; waddr = 3; wd = 32'h33;
        chk("x3_ret_p3", 2, 1);
        cyc(); chk("x3_ret_p2", 2, 1);
        cyc(); chk("x3_ret_p1_pre", 2, BYP ? 0 : 1);
        cyc(); idle();
        chk("x3_ret_p0", 2, 0);
        chk("x3_data", 0, 32'h33);

        // simultaneous issue and retire on x7
        ra1 = 7; iss_valid = 1; iss_rd = 7;
        cyc();
        we = 1; waddr = 7; wd = 32'h77;
        chk("x7_both_busy", 2, BYP ? 0 : 2);
        cyc(); idle();
        chk("x7_busy_p1", 2, 2);
        chk("x7_data", 1, 32'h77);
        cyc(); we = 1; waddr = 7; wd = 32'h77;
        cyc(); idle();
        chk("x7_drained", 2, 0);
        chk("x7_err", 4, 0);

        // underflow on x9
        ra1 = 9; we = 1; waddr = 9; wd = 32'h99;
        chk("x9_err_pre", 4, 0);
        cyc(); idle();
        chk("x9_err", 4, 1);
        chk("x9_data", 1, 32'h99);
        cyc(); chk("x9_err_sticky", 4, 1);

        // flush beats a same-cycle issue
        ra0 = 4; iss_valid = 1; iss_rd = 4;
        cyc();
        cyc(); idle();
        chk("x4_busy_p2", 2, 1);
        flush = 1; iss_valid = 1; iss_rd = 4;
        we = 1; waddr = 10; wd = 32'hAA; ra1 = 10;
        chk("x4_busy_flush_pre", 2, 1);
        cyc(); idle();
        chk("x4_busy_flushed", 2, 0);
        chk("flush_wr", 1, 32'hAA);
        chk("flush_err", 4, 1);

        // write-to-read bypass
        ra0 = 6; we = 1; waddr = 6; wd = 32'h12345678;
        chk("byp_pre", 0, BYP ? 32'h12345678 : 32'h0);
        cyc(); idle();
        chk("byp_post", 0, 32'h12345678);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the ID-stage integer register file.
- Provides NUM_RD combinational read ports and one write-back port, with x0 hardwired to zero.
- Holds a per-register pending-write scoreboard built from saturating counters, so the ID stage can detect RAW hazards against in-flight instructions.
- Sits in the ID stage. Issue events come from decode; write-back comes from the WB stage.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, at least 2; AW = log2(NREG) (localparam).
- NUM_RD, 2, number of read ports (1..4).
- CNT_W, 2, pending-counter width per register; maximum outstanding writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  port i has a nonzero pending count for its rd_addr.
- we  in  1  write-back valid; also retires one pending write.
- waddr  in  AW  write-back register index.
- wd  in  XLEN  write-back data.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- sb_full  out  1  pending[iss_rd] is saturated; issue must stall.
- flush  in  1  clears all pending counters (pipeline flush).
- sb_err  out  1  sticky flag: retire seen with a zero pending count.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers cleared to 0; all pending counters cleared to 0; sb_err cleared to 0.
  - rd_data follows the cleared array immediately.
  - Reset asserted mid-operation discards any same-cycle write or issue.
- Read path: purely combinational, zero latency.
  - rd_data[i] = mem[rd_addr[i]].
  - Register 0 always reads 0, and its rd_busy is always 0.
- Write: on the rising edge with we=1 and waddr!=0, mem[waddr] <= wd. A write to register 0 is discarded.
- Pending counter update, per register r != 0, at each rising edge:
  - inc = iss_valid & (iss_rd==r) & ~sb_full.
  - dec = we & (waddr==r).
  - inc & ~dec: count+1.
  - dec & ~inc: count-1, or, if the count is already 0, hold at 0 and set sb_err.
  - inc & dec: count unchanged.
- Saturation:
  - sb_full = iss_valid & (iss_rd!=0) & (pending[iss_rd] == 2^CNT_W-1), combinational.
  - An issue while full is not counted. Decode must hold the instruction.
  - If a retire to the same register arrives in that cycle, the count decrements normally.
- Issue to register 0: never counted; sb_full=0.
- flush=1: at the next edge, all counters go to 0. flush takes priority over inc and dec in the same cycle. The write to mem still occurs. sb_err is unaffected.
- rd_busy[i] = (pending[rd_addr[i]] != 0). It reflects registered state only; a same-cycle retire does not clear it.
- sb_err: sticky, cleared only by reset.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - Each read port whose rd_addr equals waddr while we=1 and waddr!=0 returns wd combinationally in the same cycle.
  - rd_busy for that port is forced to 0 when pending[waddr]==1, because the retiring write is the last outstanding one.
- Undefined: reads return the pre-edge array contents, and rd_busy is unmodified. Same-cycle write data becomes visible after the rising edge.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse rst low between clock edges -> rd_data for x5 is 0 immediately, sb_err=0, and all rd_busy=0.
- x0 protection: we=1, waddr=0, wd=0xFFFFFFFF; issue iss_rd=0 -> reading x0 gives 0, rd_busy=0, sb_full=0.
- Scoreboard: issue x3 three times (CNT_W=2) -> pending=3. A fourth issue shows sb_full=1 and is not counted. Three retires with we=1, waddr=3 -> rd_busy for x3 drops to 0 after the third edge.
- Simultaneous events: pending[x7]=1, with iss_valid (iss_rd=7) and we (waddr=7) in the same cycle -> pending stays 1, and mem[7]=wd.
- Underflow and flush: retire x9 with pending 0 -> sb_err=1 (sticky). Issue x4 twice, then assert flush together with iss_valid on x4 -> pending[x4]=0 next cycle.
- Bypass: we=1, waddr=6, wd=0x12345678, rd_addr0=6 in the same cycle -> with RF_WR_BYPASS_EN, rd_data0=0x12345678 before the edge; without it, the old value is read until after the edge.
